// File: rtl/flush_ctrl_pkg.sv
// Shared LC-3b types used by the pipeline flush controller.
package flush_ctrl_pkg;

  // LC-3b opcode encodings as carried in bits [15:12] of the instruction.
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  // PC mux select driven toward fetch.
  typedef enum logic [1:0] {
    NONE        = 2'd0,
    BR_TARGET   = 2'd1,
    BR_FALLTHRU = 2'd2,
    INDIRECT    = 2'd3
  } lc3b_redirect;

endpackage

// File: rtl/flush_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, return to zero on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is only ever updated with non-blocking
    // assignments so every register samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/flush_ctrl.sv
// LC-3b pipeline flush controller: resolves EX/MEM control-flow events into a
// per-stage flush vector and PC redirect, holds fetch squash for a few cycles
// afterwards, and keeps saturating performance counters.
module flush_ctrl
  import flush_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = 2,
  parameter int MEM_STAGE  = 3,
  parameter int FLUSH_HOLD = 1,
  parameter bit PREDICT_EN = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_opcode,
  input  logic                  ex_branch_enable,
  input  logic                  ex_br_prediction,
  input  logic                  mem_valid,
  input  logic [3:0]            mem_opcode,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] flush_vec,
  output logic [1:0]            redirect_sel,
  output logic                  hold_active,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  localparam int                HOLD_W    = $clog2(FLUSH_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_HOLD - 1);

  // Parameter sanity: TRAP must resolve after EX and inside the pipe.
  if (MEM_STAGE <= EX_STAGE) begin : g_bad_mem_ex
    $error("flush_ctrl: MEM_STAGE must be greater than EX_STAGE");
  end
  if (MEM_STAGE >= NUM_STAGES) begin : g_bad_mem_num
    $error("flush_ctrl: MEM_STAGE must be less than NUM_STAGES");
  end
  if (FLUSH_HOLD < 1) begin : g_bad_hold
    $error("flush_ctrl: FLUSH_HOLD must be at least 1");
  end

  logic              pred;
  logic              ex_fire;
  logic              ex_is_br;
  logic              ex_is_ind;
  logic              br_mispredict;
  logic              ex_event;
  logic              mem_event;
  logic              any_event;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;

  // Event detection: an instruction only acts on its first unstalled cycle,
  // and nothing fires while reset is asserted.
  always_comb begin
    pred          = PREDICT_EN ? ex_br_prediction : 1'b0;
    ex_fire       = rst_n & ex_valid & ~stall;
    ex_is_br      = ex_fire & (ex_opcode == op_br);
    ex_is_ind     = ex_fire & ((ex_opcode == op_jmp) | (ex_opcode == op_jsr));
    br_mispredict = ex_is_br & (ex_branch_enable != pred);
    ex_event      = br_mispredict | ex_is_ind;
    mem_event     = rst_n & mem_valid & ~stall & (mem_opcode == op_trap);
    any_event     = ex_event | mem_event;
  end

  // Flush pattern and redirect; the older MEM-stage TRAP wins over EX.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    flush_vec    = '0;
    redirect_sel = NONE;
    hold_active  = 1'b0;
    if (mem_event) begin
      for (int i = 0; i < NUM_STAGES; i++) flush_vec[i] = (i < MEM_STAGE);
      redirect_sel = INDIRECT;
    end else if (ex_event) begin
      for (int i = 0; i < NUM_STAGES; i++) flush_vec[i] = (i < EX_STAGE);
      redirect_sel = (ex_is_ind | ex_branch_enable) ? BR_TARGET : BR_FALLTHRU;
    end
    // Stale I-cache returns keep being squashed until the hold drains.
    if (rst_n && !stall && (hold_cnt_q != '0)) begin
      flush_vec[0] = 1'b1;
      hold_active  = 1'b1;
    end
  end

  // Hold counter next state: reload on any event, count down when unstalled.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (any_event) begin
      hold_cnt_d = HOLD_LOAD;
    end else if (!stall && (hold_cnt_q != '0)) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Performance counters; a same-cycle EX+MEM pair is one flush event.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (ex_is_br),
    .count (br_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (br_mispredict),
    .count (mispredict_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (any_event),
    .count (flush_count)
  );

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed scoreboard bench for flush_ctrl. Instance A: PREDICT_EN=1,
// FLUSH_HOLD=3, CNT_WIDTH=4. Instance B: PREDICT_EN=0, FLUSH_HOLD=1.
module tb_flush_ctrl;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_TRAP = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel_b;
  logic       stall;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic       ben;
  logic       pred;
  logic       mem_valid;
  logic [3:0] mem_opcode;
  logic       cnt_clr;

  logic        a_ex_valid, a_mem_valid, a_clr;
  logic        b_ex_valid, b_mem_valid, b_clr;
  logic [4:0]  a_flush, b_flush;
  logic [1:0]  a_redir, b_redir;
  logic        a_hold, b_hold;
  logic [3:0]  a_br, a_mp, a_fl;
  logic [15:0] b_br, b_mp, b_fl;

  assign a_ex_valid  = ex_valid  & ~sel_b;
  assign a_mem_valid = mem_valid & ~sel_b;
  assign a_clr       = cnt_clr   & ~sel_b;
  assign b_ex_valid  = ex_valid  &  sel_b;
  assign b_mem_valid = mem_valid &  sel_b;
  assign b_clr       = cnt_clr   &  sel_b;

  always #5 clk = ~clk;

  flush_ctrl #(
    .NUM_STAGES(5), .EX_STAGE(2), .MEM_STAGE(3),
    .FLUSH_HOLD(3), .PREDICT_EN(1'b1), .CNT_WIDTH(4)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_valid(a_ex_valid), .ex_opcode(ex_opcode),
    .ex_branch_enable(ben), .ex_br_prediction(pred),
    .mem_valid(a_mem_valid), .mem_opcode(mem_opcode), .cnt_clr(a_clr),
    .flush_vec(a_flush), .redirect_sel(a_redir), .hold_active(a_hold),
    .br_count(a_br), .mispredict_count(a_mp), .flush_count(a_fl)
  );

  flush_ctrl #(
    .NUM_STAGES(5), .EX_STAGE(2), .MEM_STAGE(3),
    .FLUSH_HOLD(1), .PREDICT_EN(1'b0), .CNT_WIDTH(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_valid(b_ex_valid), .ex_opcode(ex_opcode),
    .ex_branch_enable(ben), .ex_br_prediction(pred),
    .mem_valid(b_mem_valid), .mem_opcode(mem_opcode), .cnt_clr(b_clr),
    .flush_vec(b_flush), .redirect_sel(b_redir), .hold_active(b_hold),
    .br_count(b_br), .mispredict_count(b_mp), .flush_count(b_fl)
  );

  typedef struct {
    string      name;
    bit         sel_b;
    logic [4:0] flush;
    logic [1:0] redir;
    logic       hold;
    int         br;
    int         mp;
    int         fl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  event sample_ev;

  // Monitor: pops one expectation per sample event and compares.
  initial begin
    exp_t       e;
    logic [4:0] f;
    logic [1:0] r;
    logic       h;
    int         cb, cm, cf;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: sample with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        vectors++;
        if (e.sel_b) begin
          f = b_flush; r = b_redir; h = b_hold;
          cb = int'(b_br); cm = int'(b_mp); cf = int'(b_fl);
        end else begin
          f = a_flush; r = a_redir; h = a_hold;
          cb = int'(a_br); cm = int'(a_mp); cf = int'(a_fl);
        end
        if (f !== e.flush || r !== e.redir || h !== e.hold ||
            cb != e.br || cm != e.mp || cf != e.fl) begin
          miscompares++;
          $display("FAIL %s: got flush=%b redir=%0d hold=%b br=%0d mp=%0d fl=%0d; want flush=%b redir=%0d hold=%b br=%0d mp=%0d fl=%0d",
                   e.name, f, r, h, cb, cm, cf,
                   e.flush, e.redir, e.hold, e.br, e.mp, e.fl);
        end
      end
    end
  end

  task automatic push(input string nm, input bit sb, input logic [4:0] ef,
                      input logic [1:0] er, input logic eh,
                      input int eb, input int em, input int efl);
    exp_t e;
    e.name = nm; e.sel_b = sb; e.flush = ef; e.redir = er; e.hold = eh;
    e.br = eb; e.mp = em; e.fl = efl;
    exp_q.push_back(e);
  endtask

  // One cycle: apply inputs after the edge, sample on the falling edge.
  task automatic drive(input string nm, input bit sb, input logic st,
                       input logic exv, input logic [3:0] exo,
                       input logic be, input logic pr,
                       input logic mv, input logic [3:0] mo, input logic cc,
                       input logic [4:0] ef, input logic [1:0] er,
                       input logic eh, input int eb, input int em,
                       input int efl);
    sel_b = sb; stall = st; ex_valid = exv; ex_opcode = exo; ben = be;
    pred = pr; mem_valid = mv; mem_opcode = mo; cnt_clr = cc;
    push(nm, sb, ef, er, eh, eb, em, efl);
    @(negedge clk);
    -> sample_ev;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input bit sb, input logic st,
                      input logic [4:0] ef, input logic eh,
                      input int eb, input int em, input int efl);
    drive(nm, sb, st, 1'b0, OP_ADD, 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0,
          ef, 2'd0, eh, eb, em, efl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    // Reset state, with events presented on the inputs.
    drive("reset_gate", 0, 0, 1, OP_JMP, 0, 0, 1, OP_TRAP, 0, 5'b00000, 2'd0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Taken branch predicted not-taken, then 2 hold cycles.
    drive("mispredict", 0, 0, 1, OP_BR, 1, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 0, 0, 0);
    idle("mp_hold1", 0, 0, 5'b00001, 1, 1, 1, 1);
    idle("mp_hold2", 0, 0, 5'b00001, 1, 1, 1, 1);
    idle("mp_done",  0, 0, 5'b00000, 0, 1, 1, 1);

    // Correctly predicted taken branch: counted, no flush.
    drive("pred_ok", 0, 0, 1, OP_BR, 1, 1, 0, OP_ADD, 0, 5'b00000, 2'd0, 0, 1, 1, 1);
    idle("pred_ok_cnt", 0, 0, 5'b00000, 0, 2, 1, 1);

    // JMP with FLUSH_HOLD=3.
    drive("jmp", 0, 0, 1, OP_JMP, 0, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 2, 1, 1);
    idle("jmp_hold1", 0, 0, 5'b00001, 1, 2, 1, 2);
    idle("jmp_hold2", 0, 0, 5'b00001, 1, 2, 1, 2);
    idle("jmp_done",  0, 0, 5'b00000, 0, 2, 1, 2);

    // Mispredict in EX and TRAP in MEM together.
    drive("ex_and_trap", 0, 0, 1, OP_BR, 1, 0, 1, OP_TRAP, 0, 5'b00111, 2'd3, 0, 2, 1, 2);
    idle("both_hold1", 0, 0, 5'b00001, 1, 3, 2, 3);
    idle("both_hold2", 0, 0, 5'b00001, 1, 3, 2, 3);
    idle("both_done",  0, 0, 5'b00000, 0, 3, 2, 3);

    // JSR held behind a 4-cycle stall, then fires once.
    for (int i = 0; i < 4; i++)
      drive($sformatf("jsr_stall%0d", i), 0, 1, 1, OP_JSR, 0, 0, 0, OP_ADD, 0,
            5'b00000, 2'd0, 0, 3, 2, 3);
    drive("jsr_go", 0, 0, 1, OP_JSR, 0, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 3, 2, 3);
    idle("jsr_hold1", 0, 0, 5'b00001, 1, 3, 2, 4);
    idle("hold_stall1", 0, 1, 5'b00000, 0, 3, 2, 4);
    idle("hold_stall2", 0, 1, 5'b00000, 0, 3, 2, 4);
    idle("jsr_hold2", 0, 0, 5'b00001, 1, 3, 2, 4);
    idle("jsr_done",  0, 0, 5'b00000, 0, 3, 2, 4);

    // Not-taken branch predicted taken: fall-through redirect.
    drive("fallthru", 0, 0, 1, OP_BR, 0, 1, 0, OP_ADD, 0, 5'b00011, 2'd2, 0, 3, 2, 4);
    idle("ft_hold1", 0, 0, 5'b00001, 1, 4, 3, 5);
    idle("ft_hold2", 0, 0, 5'b00001, 1, 4, 3, 5);
    idle("ft_done",  0, 0, 5'b00000, 0, 4, 3, 5);

    // TRAP during a hold reloads the counter.
    drive("jmp2", 0, 0, 1, OP_JMP, 0, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 4, 3, 5);
    idle("jmp2_hold1", 0, 0, 5'b00001, 1, 4, 3, 6);
    drive("trap_in_hold", 0, 0, 0, OP_ADD, 0, 0, 1, OP_TRAP, 0, 5'b00111, 2'd3, 1, 4, 3, 6);
    idle("reload_hold1", 0, 0, 5'b00001, 1, 4, 3, 7);
    idle("reload_hold2", 0, 0, 5'b00001, 1, 4, 3, 7);
    idle("reload_done",  0, 0, 5'b00000, 0, 4, 3, 7);

    // Invalid slots and non-control opcodes do nothing.
    drive("invalid_slots", 0, 0, 0, OP_JMP, 1, 0, 0, OP_TRAP, 0, 5'b00000, 2'd0, 0, 4, 3, 7);
    drive("add_valid", 0, 0, 1, OP_ADD, 1, 0, 1, OP_ADD, 0, 5'b00000, 2'd0, 0, 4, 3, 7);

    // 20 back-to-back JMPs: flush_count saturates at 15.
    for (int i = 0; i < 20; i++)
      drive($sformatf("sat%0d", i), 0, 0, 1, OP_JMP, 0, 0, 0, OP_ADD, 0,
            5'b00011, 2'd1, (i > 0), 4, 3, (7 + i > 15) ? 15 : 7 + i);
    idle("sat_hold1", 0, 0, 5'b00001, 1, 4, 3, 15);
    idle("sat_hold2", 0, 0, 5'b00001, 1, 4, 3, 15);
    idle("sat_done",  0, 0, 5'b00000, 0, 4, 3, 15);

    // Clear together with a mispredict: clear wins for all counters.
    drive("clr_event", 0, 0, 1, OP_BR, 1, 0, 0, OP_ADD, 1, 5'b00011, 2'd1, 0, 4, 3, 15);
    idle("clr_hold1", 0, 0, 5'b00001, 1, 0, 0, 0);
    idle("clr_hold2", 0, 0, 5'b00001, 1, 0, 0, 0);
    idle("clr_done",  0, 0, 5'b00000, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a hold.
    drive("pre_rst_jmp", 0, 0, 1, OP_JMP, 0, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 0, 0, 0);
    idle("pre_rst_hold", 0, 0, 5'b00001, 1, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    push("async_rst", 0, 5'b00000, 2'd0, 0, 0, 0, 0);
    -> sample_ev;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("post_rst", 0, 0, 5'b00000, 0, 0, 0, 0);

    // Instance B: prediction ignored, FLUSH_HOLD=1.
    drive("b_taken_pred1", 1, 0, 1, OP_BR, 1, 1, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 0, 0, 0);
    idle("b_no_hold", 1, 0, 5'b00000, 0, 1, 1, 1);
    drive("b_nottaken", 1, 0, 1, OP_BR, 0, 1, 0, OP_ADD, 0, 5'b00000, 2'd0, 0, 1, 1, 1);
    idle("b_nt_cnt", 1, 0, 5'b00000, 0, 2, 1, 1);
    drive("b_jsr", 1, 0, 1, OP_JSR, 0, 0, 0, OP_ADD, 0, 5'b00011, 2'd1, 0, 2, 1, 1);
    idle("b_jsr_done", 1, 0, 5'b00000, 0, 2, 1, 2);

    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
- Parametrised pipeline flush controller for the LC-3b pipeline.
- Resolves control-flow events from the execute stage (branch mispredict, JMP, JSR) and the memory stage (TRAP), and drives a per-stage flush vector plus a PC redirect select.
- After each event, holds fetch squash for a configurable number of cycles so stale in-flight I-cache returns are discarded.
- Keeps saturating branch, mispredict and flush event counters for performance analysis.

Parameters:
- NUM_STAGES, 5, pipeline latch count; index 0 = fetch, increasing toward writeback.
- EX_STAGE, 2, stage index where branches/JMP/JSR resolve.
- MEM_STAGE, 3, stage index where TRAP is taken; must be > EX_STAGE.
- FLUSH_HOLD, 1, total cycles fetch squash is asserted per event (>=1).
- PREDICT_EN, 1, 1 = use ex_br_prediction; 0 = treat every branch as predicted not-taken.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global pipeline stall
- ex_valid  in  1  EX stage holds a valid instruction
- ex_opcode  in  4  EX stage opcode (lc3b_opcode)
- ex_branch_enable  in  1  BR condition evaluated taken
- ex_br_prediction  in  1  prediction carried in the instruction packet
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_opcode  in  4  MEM stage opcode
- cnt_clr  in  1  synchronous clear of all counters
- flush_vec  out  NUM_STAGES  bit i = squash stage-i latch on this edge
- redirect_sel  out  2  lc3b_redirect: NONE=0, BR_TARGET=1, BR_FALLTHRU=2, INDIRECT=3
- hold_active  out  1  post-event fetch squash in progress
- br_count  out  CNT_WIDTH  resolved conditional branches
- mispredict_count  out  CNT_WIDTH  mispredicted branches
- flush_count  out  CNT_WIDTH  flush events issued

Behaviour:
- Effective prediction: pred = PREDICT_EN ? ex_br_prediction : 0.
- ex_event = ex_valid & ~stall & ((op_br & ex_branch_enable != pred) | op_jmp | op_jsr).
- mem_event = mem_valid & ~stall & mem_opcode == op_trap.
- Priority: mem_event beats ex_event when both occur in the same cycle, because it is the older instruction.
- Events are combinational, same cycle, zero latency. While stall=1, no event fires and no counter increments. The instruction stays in its stage, so the event fires once on the first unstalled cycle.
- mem_event: flush_vec bits [MEM_STAGE-1:0] = 1, all others 0; redirect_sel = INDIRECT.
- ex_event: flush_vec bits [EX_STAGE-1:0] = 1; redirect_sel = BR_TARGET if (op_br & ex_branch_enable) or op_jmp/op_jsr, else BR_FALLTHRU.
- No event: redirect_sel = NONE.
- Hold counter hold_cnt, width $clog2(FLUSH_HOLD+1):
  - On any event, loads FLUSH_HOLD-1.
  - While hold_cnt != 0 and no stall: flush_vec[0] = 1, hold_active = 1, and hold_cnt decrements each cycle.
  - While stall=1, hold_cnt freezes.
  - A new event during hold reloads the counter and takes the new flush pattern.
  - FLUSH_HOLD = 1 means no extra cycles and hold_active is never 1.
- Counters (all saturate at all-ones, no wrap):
  - br_count += 1 on every unstalled valid op_br in EX, even when a mem_event wins that cycle.
  - mispredict_count += 1 on each mispredicted op_br.
  - flush_count += 1 per issued event; both events in one cycle count as 1.
  - cnt_clr has priority over increment in the same cycle.
- Reset (rst_n=0, asynchronous, any time, including mid-hold):
  - hold_cnt = 0 and all counters = 0.
  - flush_vec = 0, redirect_sel = NONE, hold_active = 0 (inputs are qualified by reset).
- Elaboration: assert MEM_STAGE > EX_STAGE, MEM_STAGE < NUM_STAGES, FLUSH_HOLD >= 1.

Decomposition:
- Add to lc3b_types:
  - lc3b_redirect enum (NONE, BR_TARGET, BR_FALLTHRU, INDIRECT).
  - Existing opcode constants op_br, op_jmp, op_jsr, op_trap are reused.
- Sub-module sat_counter (parameter WIDTH; ports clk, rst_n, clr, inc, count), instantiated three times.

Test Plan:
- Mispredict: PREDICT_EN=1, op_br, ex_branch_enable=1, prediction=0, no stall -> flush_vec=5'b00011, redirect_sel=BR_TARGET, br_count=1, mispredict_count=1, flush_count=1.
- Correct prediction and FLUSH_HOLD=3: correctly predicted taken branch -> flush_vec=0 and counters br=1, mispredict=0. Then op_jmp -> flush_vec=00011 for one cycle, then 00001 with hold_active=1 for 2 cycles, then 0.
- Simultaneous events: ex op_br mispredicted and mem op_trap in the same cycle -> flush_vec=00111, redirect_sel=INDIRECT, flush_count +1 only, mispredict_count +1.
- Stall: stall=1 for 4 cycles with pending op_jsr -> flush_vec=0 and no counter change. On stall drop -> single flush cycle with flush_vec=00011. Stall during hold freezes hold_cnt.
- Mode and reset: PREDICT_EN=0, taken branch with ex_br_prediction=1 -> counted as mispredict with BR_TARGET. Assert rst_n=0 mid-hold -> hold_active=0 and counters=0 immediately, without waiting for a clock edge.
- Saturation and clear: CNT_WIDTH=4, issue 20 flush events -> flush_count stays at 15. cnt_clr together with an event -> 0.
